// File: rtl/pool_pkg.sv
// pool_pkg -- shared definitions for the pooling stream generator.
//   pool_mode_e : pooling mode constants (max / average)
//   POOL_MODE   : mode selected for this build; average pooling when the
//                 macro POOL_AVG_MODE_EN is defined, max pooling otherwise
//   cnt_w()     : bits needed for a counter running 0..n-1
//   partial_w() : width of one partial-result entry for a given mode
package pool_pkg;

  typedef enum logic {
    MODE_MAX = 1'b0,
    MODE_AVG = 1'b1
  } pool_mode_e;

`ifdef POOL_AVG_MODE_EN
  localparam pool_mode_e POOL_MODE = MODE_AVG;
`else
  localparam pool_mode_e POOL_MODE = MODE_MAX;
`endif

  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Average mode keeps a full window sum, so it needs log2(POOL_SIZE^2)
  // extra bits; max mode only ever holds a pixel value.
  function automatic int partial_w(input int data_w, input int pool, input pool_mode_e mode);
    return (mode == MODE_AVG) ? data_w + 2 * $clog2(pool) : data_w;
  endfunction

endpackage

// File: rtl/pool_row_buf.sv
// pool_row_buf -- partial-result storage, one entry per window column.
// Ports:
//   clk            : clock, rising edge
//   we/waddr/wdata : write port, entry updated at the clock edge
//   raddr/rdata    : combinational read port
// The read port is combinational off the storage array and the write lands
// at the clock edge, so a read of an index in any cycle after it was written
// returns the new value. The caller combines rdata into wdata in the same
// cycle, which is why there is no combinational bypass from wdata to rdata.
// No reset: every entry is loaded by the first pixel of its window before
// it is ever read.
module pool_row_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pool_stream_gen.sv
// pool_stream_gen -- streaming POOL_SIZE x POOL_SIZE pooling (stride =
// POOL_SIZE) over a raster-order IN_W x IN_H frame.
// Build option: define POOL_AVG_MODE_EN for average pooling (truncating
// sum >> 2*log2(POOL_SIZE), POOL_SIZE must be a power of two); without it
// the block does unsigned max pooling.
// Ports:
//   clk, master_rst_n    : clock (rising edge), async active-low reset
//   in_valid/in_data     : input pixel stream, in_ready accepts
//   out_valid/out_data   : pooled result, held until out_ready
//   out_last             : qualifies the last result of the frame
//   end_op               : one-cycle pulse after the out_last result handshakes
module pool_stream_gen
  import pool_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int IN_W      = 4,
  parameter int IN_H      = 4,
  parameter int POOL_SIZE = 2
) (
  input  logic              clk,
  input  logic              master_rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              out_last,
  output logic              end_op
);

  localparam int N_WCOL = IN_W / POOL_SIZE;
  localparam int N_OROW = IN_H / POOL_SIZE;
  localparam int CW     = cnt_w(IN_W);
  localparam int PCW    = cnt_w(POOL_SIZE);
  localparam int WW     = cnt_w(N_WCOL);
  localparam int RW     = cnt_w(N_OROW);
  localparam int PART_W = partial_w(DATA_W, POOL_SIZE, POOL_MODE);

  localparam logic [CW-1:0]  COL_MAX  = CW'(IN_W - 1);
  localparam logic [PCW-1:0] P_MAX    = PCW'(POOL_SIZE - 1);
  localparam logic [WW-1:0]  WCOL_MAX = WW'(N_WCOL - 1);
  localparam logic [RW-1:0]  OROW_MAX = RW'(N_OROW - 1);

  generate
    if (POOL_SIZE < 2 || (IN_W % POOL_SIZE) != 0 || (IN_H % POOL_SIZE) != 0) begin : g_bad_geom
      $error("pool_stream_gen: POOL_SIZE must be >= 2 and divide IN_W and IN_H");
    end
    if (POOL_MODE == MODE_AVG && (POOL_SIZE & (POOL_SIZE - 1)) != 0) begin : g_bad_avg
      $error("pool_stream_gen: average pooling needs a power-of-two POOL_SIZE");
    end
  endgenerate

  logic [CW-1:0]     col;
  logic [PCW-1:0]    col_in_win;
  logic [PCW-1:0]    row_in_win;
  logic [WW-1:0]     win_col;
  logic [RW-1:0]     out_row;

  logic              accept;
  logic              first_px;
  logic              win_done;
  logic              frame_done;
  logic [PART_W-1:0] pix_ext;
  logic [PART_W-1:0] part_rd;
  logic [PART_W-1:0] part_wr;
  logic [DATA_W-1:0] result;

  assign in_ready   = !out_valid || out_ready;
  assign accept     = in_valid && in_ready;
  assign first_px   = (row_in_win == '0) && (col_in_win == '0);
  assign win_done   = (row_in_win == P_MAX) && (col_in_win == P_MAX);
  assign frame_done = win_done && (out_row == OROW_MAX) && (win_col == WCOL_MAX);

  pool_row_buf #(
    .WIDTH (PART_W),
    .DEPTH (N_WCOL),
    .AW    (WW)
  ) u_row_buf (
    .clk   (clk),
    .we    (accept),
    .waddr (win_col),
    .wdata (part_wr),
    .raddr (win_col),
    .rdata (part_rd)
  );

  always_comb begin
    pix_ext = PART_W'(in_data);
    if (first_px) begin
      part_wr = pix_ext;
    end else begin
`ifdef POOL_AVG_MODE_EN
      part_wr = part_rd + pix_ext;
`else
      part_wr = (pix_ext > part_rd) ? pix_ext : part_rd;
`endif
    end
  end

`ifdef POOL_AVG_MODE_EN
  localparam int AVG_SHIFT = 2 * $clog2(POOL_SIZE);
  assign result = DATA_W'(part_wr >> AVG_SHIFT);
`else
  assign result = part_wr[DATA_W-1:0];
`endif

  // Position counters; everything wraps to zero on the frame's final pixel
  // so the next frame can start on the very next accepted pixel.
  always_ff @(posedge clk or negedge master_rst_n) begin
    if (!master_rst_n) begin
      col        <= '0;
      col_in_win <= '0;
      row_in_win <= '0;
      win_col    <= '0;
      out_row    <= '0;
    end else if (accept) begin
      if (col_in_win == P_MAX) col_in_win <= '0;
      else                     col_in_win <= col_in_win + 1'b1;

      if (col == COL_MAX) begin
        col     <= '0;
        win_col <= '0;
        if (row_in_win == P_MAX) begin
          row_in_win <= '0;
          if (out_row == OROW_MAX) out_row <= '0;
          else                     out_row <= out_row + 1'b1;
        end else begin
          row_in_win <= row_in_win + 1'b1;
        end
      end else begin
        col <= col + 1'b1;
        if (col_in_win == P_MAX) win_col <= win_col + 1'b1;
      end
    end
  end

  // Output register. A completing window in the same cycle as a handshake
  // overrides the drop of out_valid, so the new result replaces the old one.
  always_ff @(posedge clk or negedge master_rst_n) begin
    if (!master_rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      end_op    <= 1'b0;
    end else begin
      end_op <= 1'b0;
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        end_op    <= out_last;
      end
      if (accept && win_done) begin
        out_valid <= 1'b1;
        out_data  <= result;
        out_last  <= frame_done;
      end
    end
  end

endmodule

// File: doc/pool_stream_gen.md
POOL_STREAM_GEN -- requirements
Module: pool_stream_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 8, pixel width in bits (unsigned).
REQ-002 SHALL have parameter IN_W, default 4, input frame width in pixels.
REQ-003 SHALL have parameter IN_H, default 4, input frame height in pixels.
REQ-004 SHALL have parameter POOL_SIZE, default 2, square window edge; stride equals POOL_SIZE; IN_W and IN_H multiples of POOL_SIZE; POOL_SIZE >= 2.
REQ-005 SHALL have port clk  input  1  single clock, rising edge.
REQ-006 SHALL have port master_rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port in_valid  input  1  input pixel valid.
REQ-008 SHALL have port in_data  input  DATA_W  input pixel, raster order.
REQ-009 SHALL have port in_ready  output  1  block accepts pixel this cycle.
REQ-010 SHALL have port out_valid  output  1  pooled result valid.
REQ-011 SHALL have port out_data  output  DATA_W  pooled result.
REQ-012 SHALL have port out_ready  input  1  downstream accepts result.
REQ-013 SHALL have port out_last  output  1  qualifies last result of frame.
REQ-014 SHALL have port end_op  output  1  one-cycle pulse after last result of frame is accepted.

Function
REQ-015 SHALL accept a pixel when in_valid && in_ready; in_ready = !out_valid || out_ready (combinational).
REQ-016 SHALL track col (0..IN_W-1), row-in-window (0..POOL_SIZE-1), window-column index (0..IN_W/POOL_SIZE-1), output row (0..IN_H/POOL_SIZE-1); counters advance only on accepted pixels.
REQ-017 SHALL keep one partial-result entry per window column; first pixel of a window (row-in-window 0, col%POOL_SIZE 0) loads the partial, others combine with it.
REQ-018 SHALL, in max mode, combine as unsigned max; result equals maximum of the POOL_SIZE x POOL_SIZE window.
REQ-019 SHALL assert out_valid the cycle after acceptance of the window's final pixel (row-in-window POOL_SIZE-1, col%POOL_SIZE POOL_SIZE-1); latency exactly 1 cycle.
REQ-020 SHALL hold out_valid, out_data, out_last stable until out_ready; drop out_valid on handshake unless a new result completes the same cycle.
REQ-021 SHALL set out_last with the result of the window at last output row, last window column.
REQ-022 SHALL, on final-pixel acceptance of a frame, wrap all counters to 0; next accepted pixel starts a new frame with no idle cycle.
REQ-023 SHALL pulse end_op for one cycle the cycle after the out_last result handshakes.
REQ-024 SHALL treat simultaneous output handshake and window-completing input as legal: new result replaces old, out_valid stays high.
REQ-025 SHALL ignore in_data when in_valid low; no counter or buffer change.

Reset
REQ-026 SHALL, on master_rst_n low, asynchronously clear counters, out_valid, out_data, out_last, end_op to 0; partial buffer need not clear.
REQ-027 SHALL, after reset mid-frame, restart at pixel (0,0); no result from the aborted frame emitted.

Configuration
REQ-028 SHALL support macro POOL_AVG_MODE_EN: defined -> average pooling; absent -> max pooling only.
REQ-029 SHALL, with POOL_AVG_MODE_EN, accumulate in DATA_W+2*clog2(POOL_SIZE) bits and output sum >> 2*clog2(POOL_SIZE) (truncating); POOL_SIZE shall be a power of two (elaboration error otherwise).
REQ-030 SHALL have identical handshake, latency, out_last, end_op timing in both modes.

Structure
REQ-031 SHALL place partial-width function, mode constants, and the counter-width helper in shared package pool_pkg.
REQ-032 SHALL implement the partial-result storage as sub-module pool_row_buf (IN_W/POOL_SIZE entries, one read/one write port, write-through on same-index read).

Verification
REQ-033 Max, 4x4, pool 2, pixels 0..15 raster, out_ready=1 -> results 5,7,13,15; out_last with 15; end_op one cycle later.
REQ-034 Back-pressure: out_ready=0 after first result -> in_ready drops; out_data holds 5; release -> stream resumes, no loss or duplicate.
REQ-035 Random in_valid gaps (50%), same frame -> identical results to REQ-033.
REQ-036 Reset asserted mid-frame after pixel 6, then full frame of 0..15 -> results 5,7,13,15 only.
REQ-037 POOL_AVG_MODE_EN, 4x4, pool 2, pixels 0..15 -> results 2,4,10,12.
REQ-038 Two back-to-back frames with in_valid held high -> 8 results, out_last on 4th and 8th, two end_op pulses.
